// File: rtl/serial_fa_seq_if.sv
// serial_fa_seq_if
//   Handshake and data bundle for the bit-serial adder/subtractor.
//   master: operand producer / result consumer (drives in_valid, a, b, sub, out_ready)
//   slave : the serial adder controller (drives in_ready, out_valid, sum, cout, ovf, busy)
//   Signals:
//     in_valid  operand pair present         in_ready  controller can accept operands
//     a, b      operands (WIDTH bits)        sub       1 = A-B, 0 = A+B
//     out_valid result valid                 out_ready consumer accepts result
//     sum       result mod 2^WIDTH           cout      final carry out (sub: 1 = no borrow)
//     ovf       signed overflow              busy      operation in progress or result held
interface serial_fa_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_fa_seq.sv
// serial_fa_seq
//   Bit-serial adder/subtractor: one full-adder cell is reused over WIDTH clocks,
//   LSB first. Operands are captured on the accept edge, the result is presented
//   with out_valid after WIDTH cycles and held until out_ready.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_fa_seq_if.slave (operand/result handshakes, see interface header)
module serial_fa_seq #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_fa_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s;
  logic             fa_c;

  // Full-adder cell shared across all bit positions
  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: the +1 enters through the initial carry.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = {CW{1'b0}};
          sum_d   = {WIDTH{1'b0}};
          cmsb_d  = 1'b0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        // Carry out of bit WIDTH-2 is the carry into the MSB, needed for ovf.
        if (cnt_q == CNT_PRE) begin
          cmsb_d = fa_c;
        end else begin
          cmsb_d = cmsb_q;
        end
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_c;
          ovf_d   = cmsb_q ^ fa_c;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags decode from the state register only
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/serial_fa_seq.md
# serial_fa_seq

Bit-serial adder/subtractor controller that time-multiplexes a single full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It sits between the FPU mantissa/exponent datapath and the FA cell, trading latency for area. It owns the operand shift registers, the carry flip-flop, the bit counter and a three-state FSM, and it exposes valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand and result width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = compute A-B, 0 = A+B; sampled with operands
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, two's-complement modulo 2^WIDTH
- cout  output  1  final carry out (for sub: 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN and DONE

## Operation
- One clock; reset is asynchronous and active-low (rst_n). Reset forces state IDLE, counter=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 and busy=0 while in IDLE.
- FSM states:
  - IDLE: in_ready=1. When in_valid && in_ready: load A into shift register, load B (or ~B if sub=1) into shift register, set carry=sub, clear counter and sum, go to RUN.
  - RUN: each cycle the FA cell takes A[0], B'[0] and carry. The sum bit shifts into sum from the MSB side (sum <= {s, sum[WIDTH-1:1]}), A and B' shift right, carry <= FA cout, counter increments. On the cycle counter==WIDTH-2, latch the current carry as carry-into-MSB. On the cycle counter==WIDTH-1, go to DONE, set cout=FA cout, ovf=carry_into_MSB ^ FA cout, and out_valid=1.
  - DONE: out_valid=1. sum, cout and ovf are held stable. When out_ready=1, go to IDLE and drop out_valid. sum, cout and ovf keep their values until the next load.
- in_valid outside IDLE is ignored. No operand is captured and there is no queuing.
- a, b and sub are sampled only at the accept edge; later changes have no effect.
- Arithmetic: sum = (A + B' + sub) mod 2^WIDTH, where B' = sub ? ~B : B.
- Reset mid-operation aborts immediately with no partial result presented. The first valid accept after reset starts a clean operation.

## Timing
- Accept at edge E0. RUN spans edges E1..E_WIDTH. out_valid rises after E_WIDTH, so the latency is WIDTH cycles from accept to out_valid.
- Minimum throughput is one operation per WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with out_ready=1, then back to IDLE.
- The DONE→IDLE transition happens at the edge where out_valid && out_ready. in_ready rises in the following cycle, so there is no accept in the same cycle as the result handoff.
- All outputs are registered or decoded from the state register only. There are no combinational paths from in_valid or out_ready to in_ready or out_valid.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps inside an operation.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, sub=0 -> after 8 cycles, sum=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum/cout/ovf are unchanged. Also toggle in_valid with new a/b during RUN/DONE -> in_ready=0 and the result is unaffected.
- Reset mid-RUN: assert rst_n=0 at bit 3 -> out_valid=0, sum=0, cout=0, ovf=0 and in_ready=1 immediately (asynchronously). The next operation (0x01+0x01) yields 0x02.
- Back-to-back: keep in_valid=1 and out_ready=1 continuously with random operands for 1000 ops -> each result matches the reference model and accepts are spaced exactly WIDTH+2 cycles apart.
